// File: rtl/muldiv_ctrl_if.sv
// Pipeline-side bundle for the iterative multiply/divide sequencer:
// launch/MT controls toward the unit and HI/LO/busy/done back.
interface muldiv_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_start;
    logic [1:0]       i_op;
    logic [WIDTH-1:0] i_op1;
    logic [WIDTH-1:0] i_op2;
    logic             i_mthi;
    logic             i_mtlo;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_start, i_op, i_op1, i_op2, i_mthi, i_mtlo,
        input  o_hi, o_lo, o_busy, o_done
    );

    modport slave (
        input  i_start, i_op, i_op1, i_op2, i_mthi, i_mtlo,
        output o_hi, o_lo, o_busy, o_done
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO: shift-add multiply,
// restoring divide, one bit per cycle, sign correction in a final FIX cycle.
module muldiv_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    muldiv_ctrl_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH:0]   acc, acc_nxt;      // product high half / partial remainder
    logic [WIDTH-1:0] low, low_nxt;      // multiplier / quotient
    logic [WIDTH-1:0] mcand, mcand_nxt;  // multiplicand / divisor magnitude
    logic             is_div, is_div_nxt;
    logic             q_neg, q_neg_nxt;
    logic             r_neg, r_neg_nxt;
    logic [WIDTH-1:0] hi, hi_nxt;
    logic [WIDTH-1:0] lo, lo_nxt;
    logic             busy, busy_nxt;
    logic             done, done_nxt;

    logic             signed_op;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign signed_op = ~bus.i_op[0];
    assign mag1 = (signed_op && bus.i_op1[WIDTH-1]) ? -bus.i_op1 : bus.i_op1;
    assign mag2 = (signed_op && bus.i_op2[WIDTH-1]) ? -bus.i_op2 : bus.i_op2;

    // Iteration datapath: multiply add-then-shift-right, divide shift-left-then-trial
    assign sum      = low[0] ? (acc + {1'b0, mcand}) : acc;
    assign shifted  = {acc[WIDTH-1:0], low[WIDTH-1]};
    assign prod     = {acc[WIDTH-1:0], low};
    assign prod_fix = q_neg ? -prod : prod;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            low    <= '0;
            mcand  <= '0;
            is_div <= 1'b0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            acc    <= acc_nxt;
            low    <= low_nxt;
            mcand  <= mcand_nxt;
            is_div <= is_div_nxt;
            q_neg  <= q_neg_nxt;
            r_neg  <= r_neg_nxt;
            hi     <= hi_nxt;
            lo     <= lo_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        acc_nxt    = acc;
        low_nxt    = low;
        mcand_nxt  = mcand;
        is_div_nxt = is_div;
        q_neg_nxt  = q_neg;
        r_neg_nxt  = r_neg;
        hi_nxt     = hi;
        lo_nxt     = lo;

        case (state)
            IDLE: begin
                if (bus.i_mthi) hi_nxt = bus.i_op1;
                if (bus.i_mtlo) lo_nxt = bus.i_op1;
                if (bus.i_start) begin
                    is_div_nxt = bus.i_op[1];
                    q_neg_nxt  = signed_op & (bus.i_op1[WIDTH-1] ^ bus.i_op2[WIDTH-1]);
                    r_neg_nxt  = signed_op & bus.i_op1[WIDTH-1];
                    acc_nxt    = '0;
                    cnt_nxt    = CW'(WIDTH);
                    state_nxt  = CALC;
                    if (bus.i_op[1]) begin
                        mcand_nxt = mag2;
                        low_nxt   = mag1;
                        // Divide by zero: FIX commits quot=all ones, rem=raw dividend
                        if (bus.i_op2 == '0) begin
                            acc_nxt   = {1'b0, bus.i_op1};
                            low_nxt   = '1;
                            q_neg_nxt = 1'b0;
                            r_neg_nxt = 1'b0;
                            cnt_nxt   = '0;
                            state_nxt = FIX;
                        end
                    end else begin
                        mcand_nxt = mag1;
                        low_nxt   = mag2;
                    end
                end
            end
            CALC: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) state_nxt = FIX;
                if (is_div) begin
                    if (shifted >= {1'b0, mcand}) begin
                        acc_nxt = shifted - {1'b0, mcand};
                        low_nxt = {low[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_nxt = shifted;
                        low_nxt = {low[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_nxt = {1'b0, sum[WIDTH:1]};
                    low_nxt = {sum[0], low[WIDTH-1:1]};
                end
            end
            FIX: begin
                state_nxt = IDLE;
                if (is_div) begin
                    lo_nxt = q_neg ? -low : low;
                    hi_nxt = r_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                end else begin
                    hi_nxt = prod_fix[2*WIDTH-1:WIDTH];
                    lo_nxt = prod_fix[WIDTH-1:0];
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state == FIX);
    end

    assign bus.o_hi   = hi;
    assign bus.o_lo   = lo;
    assign bus.o_busy = busy;
    assign bus.o_done = done;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: per-feature tasks with hand-computed
// HI/LO, latency, busy length and done-pulse expectations.
module tb_muldiv_ctrl;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    muldiv_ctrl_if #(.WIDTH(32)) bus ();
    muldiv_ctrl #(.WIDTH(32)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the first negedge after the start edge
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.i_op    = op;
        bus.i_op1   = a;
        bus.i_op2   = b;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    // Observation k=1 is the current negedge; done_at=0 means it never came
    task automatic wait_done(input bit extra, output int done_at, output int busy_cyc,
                             output logic done_again);
        done_at    = 0;
        busy_cyc   = 0;
        done_again = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (bus.o_busy) busy_cyc++;
            if (bus.o_done) begin
                done_at = k;
                break;
            end
            @(negedge clk);
        end
        if (extra && done_at != 0) begin
            @(negedge clk);
            done_again = bus.o_done;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (bus.o_hi !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h want 0", bus.o_hi); end
        tests++; if (bus.o_lo !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h want 0", bus.o_lo); end
        tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
        tests++; if (bus.o_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int d, b; logic again;
        issue(2'b00, 32'hFFFF_FFFD, 32'd5);
        wait_done(1'b1, d, b, again);
        tests++; if (d != 34) begin fails++; $display("FAIL mult_latency: got %0d want 34", d); end
        tests++; if (b != 33) begin fails++; $display("FAIL mult_busy_cycles: got %0d want 33", b); end
        tests++; if (again !== 1'b0) begin fails++; $display("FAIL mult_done_pulse: got %b want 0", again); end
        tests++; if (bus.o_hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mult_hi: got %h want ffffffff", bus.o_hi); end
        tests++; if (bus.o_lo !== 32'hFFFF_FFF1) begin fails++; $display("FAIL mult_lo: got %h want fffffff1", bus.o_lo); end
    endtask

    task automatic test_multu();
        int d, b; logic again;
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1'b1, d, b, again);
        tests++; if (bus.o_hi !== 32'hFFFF_FFFE) begin fails++; $display("FAIL multu_hi: got %h want fffffffe", bus.o_hi); end
        tests++; if (bus.o_lo !== 32'h0000_0001) begin fails++; $display("FAIL multu_lo: got %h want 00000001", bus.o_lo); end
    endtask

    task automatic test_div();
        int d, b; logic again;
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(1'b1, d, b, again);
        tests++; if (bus.o_lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_neg_lo: got %h want fffffffd", bus.o_lo); end
        tests++; if (bus.o_hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_neg_hi: got %h want ffffffff", bus.o_hi); end
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1'b1, d, b, again);
        tests++; if (bus.o_lo !== 32'h8000_0000) begin fails++; $display("FAIL div_ovf_lo: got %h want 80000000", bus.o_lo); end
        tests++; if (bus.o_hi !== 32'h0) begin fails++; $display("FAIL div_ovf_hi: got %h want 0", bus.o_hi); end
    endtask

    task automatic test_divu();
        int d, b; logic again;
        issue(2'b11, 32'd100, 32'd7);
        wait_done(1'b1, d, b, again);
        tests++; if (bus.o_lo !== 32'd14) begin fails++; $display("FAIL divu_lo: got %0d want 14", bus.o_lo); end
        tests++; if (bus.o_hi !== 32'd2) begin fails++; $display("FAIL divu_hi: got %0d want 2", bus.o_hi); end
        issue(2'b11, 32'd5, 32'd0);
        wait_done(1'b1, d, b, again);
        tests++; if (d != 2) begin fails++; $display("FAIL divz_latency: got %0d want 2", d); end
        tests++; if (b != 1) begin fails++; $display("FAIL divz_busy_cycles: got %0d want 1", b); end
        tests++; if (bus.o_lo !== 32'hFFFF_FFFF) begin fails++; $display("FAIL divz_lo: got %h want ffffffff", bus.o_lo); end
        tests++; if (bus.o_hi !== 32'd5) begin fails++; $display("FAIL divz_hi: got %h want 5", bus.o_hi); end
    endtask

    task automatic test_mt();
        bus.i_op1  = 32'h1234;
        bus.i_mthi = 1'b1;
        @(negedge clk);
        bus.i_mthi = 1'b0;
        tests++; if (bus.o_hi !== 32'h1234) begin fails++; $display("FAIL mthi_hi: got %h want 1234", bus.o_hi); end
        tests++; if (bus.o_done !== 1'b0) begin fails++; $display("FAIL mthi_no_done: got %b want 0", bus.o_done); end
        bus.i_op1  = 32'hABCD;
        bus.i_mtlo = 1'b1;
        @(negedge clk);
        bus.i_mtlo = 1'b0;
        tests++; if (bus.o_lo !== 32'hABCD) begin fails++; $display("FAIL mtlo_lo: got %h want abcd", bus.o_lo); end
        tests++; if (bus.o_hi !== 32'h1234) begin fails++; $display("FAIL mtlo_hi_kept: got %h want 1234", bus.o_hi); end
        tests++; if (bus.o_done !== 1'b0) begin fails++; $display("FAIL mtlo_no_done: got %b want 0", bus.o_done); end
    endtask

    task automatic test_busy_ignore();
        int d, b; logic again;
        issue(2'b11, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        bus.i_op    = 2'b01;
        bus.i_op1   = 32'hDEAD;
        bus.i_op2   = 32'd3;
        bus.i_mthi  = 1'b1;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_mthi  = 1'b0;
        bus.i_start = 1'b0;
        tests++; if (bus.o_hi !== 32'h1234) begin fails++; $display("FAIL busy_mthi_hi: got %h want 1234", bus.o_hi); end
        tests++; if (bus.o_busy !== 1'b1) begin fails++; $display("FAIL busy_still: got %b want 1", bus.o_busy); end
        wait_done(1'b1, d, b, again);
        tests++; if (d == 0) begin fails++; $display("FAIL busy_done_timeout: got none want done"); end
        tests++; if (bus.o_lo !== 32'd14) begin fails++; $display("FAIL busy_start_lo: got %0d want 14", bus.o_lo); end
        tests++; if (bus.o_hi !== 32'd2) begin fails++; $display("FAIL busy_start_hi: got %0d want 2", bus.o_hi); end
    endtask

    task automatic test_back_to_back();
        int d, b; logic again;
        issue(2'b11, 32'd100, 32'd7);
        wait_done(1'b0, d, b, again);
        tests++; if (bus.o_done !== 1'b1) begin fails++; $display("FAIL b2b_first_done: got %b want 1", bus.o_done); end
        issue(2'b01, 32'd6, 32'd7);
        wait_done(1'b1, d, b, again);
        tests++; if (d != 34) begin fails++; $display("FAIL b2b_latency: got %0d want 34", d); end
        tests++; if (bus.o_lo !== 32'd42) begin fails++; $display("FAIL b2b_lo: got %0d want 42", bus.o_lo); end
        tests++; if (bus.o_hi !== 32'd0) begin fails++; $display("FAIL b2b_hi: got %0d want 0", bus.o_hi); end
    endtask

    task automatic test_reset_mid();
        int d, b; logic again;
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++; if (bus.o_hi !== 32'h0) begin fails++; $display("FAIL rstmid_hi: got %h want 0", bus.o_hi); end
        tests++; if (bus.o_lo !== 32'h0) begin fails++; $display("FAIL rstmid_lo: got %h want 0", bus.o_lo); end
        tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", bus.o_busy); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(2'b00, 32'd6, 32'd7);
        wait_done(1'b1, d, b, again);
        tests++; if (d != 34) begin fails++; $display("FAIL rstmid_latency: got %0d want 34", d); end
        tests++; if (bus.o_lo !== 32'd42) begin fails++; $display("FAIL rstmid_lo_after: got %0d want 42", bus.o_lo); end
        tests++; if (bus.o_hi !== 32'd0) begin fails++; $display("FAIL rstmid_hi_after: got %0d want 0", bus.o_hi); end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_op    = 2'b00;
        bus.i_op1   = '0;
        bus.i_op2   = '0;
        bus.i_mthi  = 1'b0;
        bus.i_mtlo  = 1'b0;
        @(negedge clk);
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_divu();
        test_mt();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
